// File: rtl/node_msg_pkg.sv
// Shared types and constants for the node inbound message writer:
// FSM encoding, CSR word map and ring header field layout.
package node_msg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_HEADER  = 2'd2
  } state_t;

  localparam logic [1:0] CSR_HEAD  = 2'd0;
  localparam logic [1:0] CSR_TAIL  = 2'd1;
  localparam logic [1:0] CSR_CTRL  = 2'd2;
  localparam logic [1:0] CSR_COUNT = 2'd3;

  localparam int HDR_TRUNC_BIT = 15;
  localparam int HDR_LEN_MSB   = 14;

  // Packs the truncation flag and stored length into the ring header word.
  function automatic logic [15:0] make_header(input logic trunc,
                                              input logic [HDR_LEN_MSB:0] len);
    logic [15:0] hdr;
    hdr                  = 16'h0000;
    hdr[HDR_TRUNC_BIT]   = trunc;
    hdr[HDR_LEN_MSB:0]   = len;
    return hdr;
  endfunction

endpackage

// File: rtl/node_msg_rx_writer_if.sv
// Inbound flit stream from the node network receive path.
interface node_msg_rx_writer_if;
  logic        valid;
  logic        ready;
  logic [15:0] data;
  logic        sop;
  logic        eop;

  modport master (output valid, data, sop, eop, input ready);
  modport slave  (input valid, data, sop, eop, output ready);
endinterface

// File: rtl/node_msg_rx_writer_csr.sv
// CSR slave for the inbound ring: tail pointer, interrupt enable/pending,
// packet counter and the registered read mux.
module node_msg_csr
  import node_msg_pkg::*;
#(
  parameter int RING_WORDS = 4096,
  parameter int OFF_W      = $clog2(RING_WORDS)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       csr_address,
  input  logic             csr_read,
  input  logic             csr_write,
  input  logic [31:0]      csr_writedata,
  output logic [31:0]      csr_readdata,
  output logic             irq,
  input  logic             publish_i,
  input  logic [OFF_W-1:0] head_i,
  output logic [OFF_W-1:0] tail_o
);

  logic [OFF_W-1:0] tail_q, tail_d;
  logic             irq_en_q, irq_en_d;
  logic             irq_pend_q, irq_pend_d;
  logic [31:0]      count_q, count_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             irq_q, irq_d;
  logic             wr_tail_s, wr_ctrl_s;

  assign wr_tail_s = csr_write && (csr_address == CSR_TAIL);
  assign wr_ctrl_s = csr_write && (csr_address == CSR_CTRL);

  // Next-state for the register file; a publish beats a same-cycle W1C.
  always_comb begin
    tail_d     = tail_q;
    irq_en_d   = irq_en_q;
    irq_pend_d = irq_pend_q;
    count_d    = count_q;
    rdata_d    = rdata_q;

    if (wr_tail_s && (csr_writedata < 32'(RING_WORDS))) tail_d = csr_writedata[OFF_W-1:0];
    else                                                tail_d = tail_q;

    if (wr_ctrl_s) irq_en_d = csr_writedata[0];
    else           irq_en_d = irq_en_q;

    if (publish_i)                        irq_pend_d = 1'b1;
    else if (wr_ctrl_s && csr_writedata[1]) irq_pend_d = 1'b0;
    else                                  irq_pend_d = irq_pend_q;

    if (publish_i) count_d = count_q + 32'd1;
    else           count_d = count_q;

    if (csr_read) begin
      case (csr_address)
        CSR_HEAD:  rdata_d = 32'(head_i);
        CSR_TAIL:  rdata_d = 32'(tail_q);
        CSR_CTRL:  rdata_d = {30'd0, irq_pend_q, irq_en_q};
        CSR_COUNT: rdata_d = count_q;
        default:   rdata_d = 32'd0;
      endcase
    end else begin
      rdata_d = rdata_q;
    end

    irq_d = irq_en_d & irq_pend_d;
  end

  // CSR state register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tail_q     <= {OFF_W{1'b0}};
      irq_en_q   <= 1'b0;
      irq_pend_q <= 1'b0;
      count_q    <= 32'd0;
      rdata_q    <= 32'd0;
      irq_q      <= 1'b0;
    end else begin
      tail_q     <= tail_d;
      irq_en_q   <= irq_en_d;
      irq_pend_q <= irq_pend_d;
      count_q    <= count_d;
      rdata_q    <= rdata_d;
      irq_q      <= irq_d;
    end
  end

  assign csr_readdata = rdata_q;
  assign irq          = irq_q;
  assign tail_o       = tail_q;

endmodule

// File: rtl/node_msg_rx_writer.sv
// Inbound message writer: frames received packets into a ring in processing
// memory port 2 and publishes the head pointer once the header is written.
module node_msg_rx_writer
  import node_msg_pkg::*;
#(
  parameter int ADDR_W        = 14,
  parameter int RING_BASE     = 10752,
  parameter int RING_WORDS    = 4096,
  parameter int MAX_PKT_WORDS = 64
) (
  input  logic                 clk,
  input  logic                 reset_n,
  node_msg_rx_writer_if.slave  rx,
  output logic [ADDR_W-1:0]    mem_address,
  output logic [15:0]          mem_writedata,
  output logic [1:0]           mem_byteenable,
  output logic                 mem_chipselect,
  output logic                 mem_write,
  output logic                 mem_clken,
  input  logic [1:0]           csr_address,
  input  logic                 csr_read,
  input  logic                 csr_write,
  input  logic [31:0]          csr_writedata,
  output logic [31:0]          csr_readdata,
  output logic                 irq
);

  localparam int OFF_W = $clog2(RING_WORDS);
  localparam int LEN_W = HDR_LEN_MSB + 1;

  state_t           state_q, state_d;
  logic [OFF_W-1:0] head_q, head_d, wr_ptr_q, wr_ptr_d;
  logic [LEN_W-1:0] pkt_len_q, pkt_len_d;
  logic             trunc_q, trunc_d;
  logic [OFF_W-1:0] tail_s, used_s, wr_off_s;
  logic [OFF_W:0]   free_s;
  logic             room_s, ready_s, wr_en_s, publish_s;
  logic [15:0]      wr_data_s;

  // A new packet is only started when a maximum-size packet plus header fits.
  assign used_s = head_q - tail_s;
  assign free_s = (OFF_W+1)'(RING_WORDS - 1) - {1'b0, used_s};
  assign room_s = free_s >= (OFF_W+1)'(MAX_PKT_WORDS + 1);

  // Packet framing FSM: payload goes at head+1.., header at head, then publish.
  always_comb begin
    state_d   = state_q;
    head_d    = head_q;
    wr_ptr_d  = wr_ptr_q;
    pkt_len_d = pkt_len_q;
    trunc_d   = trunc_q;
    ready_s   = 1'b0;
    wr_en_s   = 1'b0;
    wr_off_s  = wr_ptr_q;
    wr_data_s = rx.data;
    publish_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ready_s = room_s;
        if (rx.valid && room_s && rx.sop) begin
          wr_en_s   = 1'b1;
          wr_off_s  = head_q + OFF_W'(1);
          wr_ptr_d  = head_q + OFF_W'(2);
          pkt_len_d = LEN_W'(1);
          trunc_d   = 1'b0;
          state_d   = rx.eop ? ST_HEADER : ST_PAYLOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PAYLOAD: begin
        // A sop here means the previous packet lost its eop: close it first.
        ready_s = ~rx.sop;
        if (rx.valid && rx.sop) begin
          trunc_d = 1'b1;
          state_d = ST_HEADER;
        end else if (rx.valid) begin
          if (pkt_len_q < LEN_W'(MAX_PKT_WORDS)) begin
            wr_en_s   = 1'b1;
            wr_ptr_d  = wr_ptr_q + OFF_W'(1);
            pkt_len_d = pkt_len_q + LEN_W'(1);
          end else begin
            trunc_d = 1'b1;
          end
          state_d = rx.eop ? ST_HEADER : ST_PAYLOAD;
        end else begin
          state_d = ST_PAYLOAD;
        end
      end
      ST_HEADER: begin
        wr_en_s   = 1'b1;
        wr_off_s  = head_q;
        wr_data_s = make_header(trunc_q, pkt_len_q);
        publish_s = 1'b1;
        head_d    = wr_ptr_q;
        trunc_d   = 1'b0;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Framing state register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      head_q    <= {OFF_W{1'b0}};
      wr_ptr_q  <= {OFF_W{1'b0}};
      pkt_len_q <= {LEN_W{1'b0}};
      trunc_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      head_q    <= head_d;
      wr_ptr_q  <= wr_ptr_d;
      pkt_len_q <= pkt_len_d;
      trunc_q   <= trunc_d;
    end
  end

  assign rx.ready       = reset_n & ready_s;
  assign mem_write      = reset_n & wr_en_s;
  assign mem_chipselect = reset_n & wr_en_s;
  assign mem_address    = ADDR_W'(RING_BASE) + ADDR_W'(wr_off_s);
  assign mem_writedata  = wr_data_s;
  assign mem_byteenable = 2'b11;
  assign mem_clken      = 1'b1;

  node_msg_csr #(
    .RING_WORDS (RING_WORDS),
    .OFF_W      (OFF_W)
  ) u_csr (
    .clk           (clk),
    .reset_n       (reset_n),
    .csr_address   (csr_address),
    .csr_read      (csr_read),
    .csr_write     (csr_write),
    .csr_writedata (csr_writedata),
    .csr_readdata  (csr_readdata),
    .irq           (irq),
    .publish_i     (publish_s),
    .head_i        (head_q),
    .tail_o        (tail_s)
  );

endmodule

// File: doc/node_msg_rx_writer.md
Name: node_msg_rx_writer

Overview:
- Inbound message writer for a node's dual-port processing memory: accepts 16-bit packet flits from the node's network receive path and writes them through the memory's 16-bit second port (s2) into a ring buffer.
- Frames each packet with a length header and publishes a head pointer and interrupt to the Nios core. The Nios reads packets via the 32-bit port and returns space by writing the tail pointer over a small CSR slave.

Parameters:
- ADDR_W, 14, width of the memory port-2 word address
- RING_BASE, 10752, first 16-bit word address of the ring in processing memory
- RING_WORDS, 4096, ring size in 16-bit words (power of two; RING_BASE+RING_WORDS ≤ 15000)
- MAX_PKT_WORDS, 64, maximum payload words stored per packet

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- in_valid  in  1  inbound flit valid
- in_ready  out  1  inbound flit accepted when in_valid&in_ready
- in_data  in  16  flit payload
- in_sop  in  1  first flit of packet
- in_eop  in  1  last flit of packet
- mem_address  out  ADDR_W  word address to memory port 2
- mem_writedata  out  16  write data to port 2
- mem_byteenable  out  2  constant 2'b11
- mem_chipselect  out  1  asserted with mem_write
- mem_write  out  1  single-cycle write strobe
- mem_clken  out  1  constant 1
- csr_address  in  2  CSR word select
- csr_read  in  1  CSR read strobe
- csr_write  in  1  CSR write strobe
- csr_writedata  in  32  CSR write data
- csr_readdata  out  32  CSR read data, registered
- irq  out  1  packet-available interrupt

Behaviour:
- Reset (reset_n=0 at a clk edge): head=0, tail=0, wr_ptr=0, pkt_len=0, state=IDLE, irq_en=0, irq_pending=0, pkt_count=0; outputs in_ready=0, mem_write=0, mem_chipselect=0, csr_readdata=0, irq=0. A partially received packet is discarded because head has not been published.
- Offsets are RING_WORDS-wide modulo counters. mem_address = RING_BASE + offset. used = head - tail (mod RING_WORDS). free = RING_WORDS-1-used.
- FSM states: IDLE, PAYLOAD, HEADER.
- IDLE:
  - in_ready=1 only if free ≥ MAX_PKT_WORDS+1.
  - A non-sop flit is accepted and dropped, with no write.
  - On an accepted sop flit: header slot = head; write flit at head+1; wr_ptr=head+2; pkt_len=1.
  - If in_eop is also set, go to HEADER; else go to PAYLOAD.
- PAYLOAD:
  - in_ready=1, except in_ready=0 when in_sop=1 (missing eop). In that case set trunc and go to HEADER without consuming the flit; it is accepted later from IDLE.
  - Each accepted flit is written at wr_ptr if pkt_len < MAX_PKT_WORDS, then wr_ptr++ and pkt_len++. Otherwise the flit is dropped and trunc=1.
  - On accepted eop, go to HEADER.
- HEADER:
  - in_ready=0.
  - Single write at the header slot, data = {trunc, pkt_len[14:0]}.
  - Next cycle: head=wr_ptr, pkt_count++, irq_pending=1, trunc=0, state=IDLE.
- Memory writes: at most one per cycle, combinationally driven from registered state. Latency is 0 cycles from flit acceptance to mem_write. Port 2 is never read by this block.
- Write-path ordering: the header is always written before head is published, and payload words before the header.
- CSR map:
  - 0: head (RO).
  - 1: tail (RW). A write with value ≥ RING_WORDS is ignored.
  - 2: bit0 irq_en (RW), bit1 irq_pending (W1C).
  - 3: pkt_count (RO, 32-bit wrapping).
- CSR reads have 1-cycle latency. csr_readdata is held otherwise.
- If a publish and a W1C of irq_pending occur in the same cycle, the set wins.
- irq = irq_en & irq_pending, registered.
- A tail write in the same cycle as a publish: both take effect. free is recomputed next cycle.
- Wrap: the ring is contiguous modulo RING_WORDS, so a packet may straddle the end of the ring. The consumer handles wrap.

Decomposition:
- Package node_msg_pkg holds:
  - FSM state enum (IDLE/PAYLOAD/HEADER)
  - CSR offsets (CSR_HEAD=0, CSR_TAIL=1, CSR_CTRL=2, CSR_COUNT=3)
  - header field positions (HDR_TRUNC_BIT=15, HDR_LEN_MSB=14)
- One natural sub-module, node_msg_csr: CSR register file, irq logic, and tail register.

Test Plan:
- Reset, then a 3-flit packet 0xA001,0xA002,0xA003 (sop on first, eop on last) -> writes at 10753..10755, then header 0x0003 at 10752; head reads 4; irq=1 after irq_en=1.
- Single-flit packet with sop+eop, data 0xBEEF -> write 0xBEEF at head+1, then header 0x0001; head advances by 2.
- 70-flit packet -> 64 payload writes, header 0x8040, head advances by 65.
- Fill the ring with tail=0 until free < 65 -> in_ready=0 in IDLE; CSR write tail=130 -> in_ready=1 next cycle.
- Packet lacking eop followed by a new sop -> first packet header has bit15 set; the second packet is written intact after it.
- Reset asserted mid-PAYLOAD -> head=0, no header written, in_ready=0 during reset; next packet lands at 10752.
